// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the pipeline memory arbiter slice:
//   WORD_W       - data/address word width
//   TIMEOUT_DATA - read data returned when the watchdog abandons a transaction
//   arb_state_t  - arbiter FSM states
// -----------------------------------------------------------------------------
package arm_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [WORD_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DATA,
      RESP
   } arb_state_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// -----------------------------------------------------------------------------
// mem_arb_watchdog
// Counts cycles while count_en is high and flags expiry in the cycle that
// completes TIMEOUT_CYCLES consecutive counted cycles.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   count_en - count this cycle (memory transaction outstanding)
//   clear    - synchronous clear, has priority over counting
//   expired  - high during the TIMEOUT_CYCLES-th counted cycle
// -----------------------------------------------------------------------------
module mem_arb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic count_en,
   input  logic clear,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] count;

   // Combinational so the FSM can leave on the same edge that ends the
   // final allowed cycle.
   assign expired = count_en && (count == LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && !expired) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pipeline_mem_arbiter
// Shares one memory port between instruction fetch and memory-stage data
// accesses. Data wins by default; a waiting fetch is forced through after
// FETCH_STARVE_MAX consecutive data grants.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abandon a transaction after
// TIMEOUT_CYCLES cycles without MemAck (returns 32'hDEADBEEF, sets sticky
// ErrTimeout). Without the macro ErrTimeout is tied low.
// Ports:
//   CLK, RST                     - clock, async active-low reset
//   IReqF, IAddrF                - fetch request / address
//   IRdataF, IReadyF             - fetched word / one-cycle done pulse
//   DReqM, DWeM, DAddrM, DWdataM - data request, write enable, addr, wdata
//   DRdataM, DReadyM             - load data / one-cycle done pulse
//   MemReq, MemWe, MemAddr, MemWdata, MemRdata, MemAck - memory port
//   ErrTimeout                   - sticky watchdog error
// -----------------------------------------------------------------------------
module pipeline_mem_arbiter
   import arm_pkg::*;
#(
   parameter int unsigned FETCH_STARVE_MAX = 4,
   parameter int unsigned TIMEOUT_CYCLES   = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IReqF,
   input  logic [WORD_W-1:0] IAddrF,
   output logic [WORD_W-1:0] IRdataF,
   output logic              IReadyF,
   input  logic              DReqM,
   input  logic              DWeM,
   input  logic [WORD_W-1:0] DAddrM,
   input  logic [WORD_W-1:0] DWdataM,
   output logic [WORD_W-1:0] DRdataM,
   output logic              DReadyM,
   output logic              MemReq,
   output logic              MemWe,
   output logic [WORD_W-1:0] MemAddr,
   output logic [WORD_W-1:0] MemWdata,
   input  logic [WORD_W-1:0] MemRdata,
   input  logic              MemAck,
   output logic              ErrTimeout
);

   localparam int unsigned STARVE_W =
      (FETCH_STARVE_MAX < 1) ? 1 : $clog2(FETCH_STARVE_MAX + 1);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(FETCH_STARVE_MAX);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("pipeline_mem_arbiter: TIMEOUT_CYCLES must be 1..255");
   end

   arb_state_t          state;
   arb_state_t          state_nxt;
   logic [STARVE_W-1:0] starve;
   logic                grant_fetch;
   logic                grant_data;
   logic                mem_busy;
   logic                txn_done;
   logic                resp_fetch;
   logic                wd_expired;
   logic [WORD_W-1:0]   resp_data;

   assign mem_busy = (state == FETCH) || (state == DATA);
   // MemAck wins over a simultaneous watchdog expiry.
   assign txn_done  = mem_busy && (MemAck || wd_expired);
   assign resp_data = MemAck ? MemRdata : TIMEOUT_DATA;

   assign MemReq  = mem_busy;
   assign IReadyF = (state == RESP) && resp_fetch;
   assign DReadyM = (state == RESP) && !resp_fetch;

`ifdef MEM_ARB_TIMEOUT_EN
   logic err_q;

   mem_arb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (CLK),
      .rst_n   (RST),
      .count_en(mem_busy),
      .clear   (!mem_busy),
      .expired (wd_expired)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         err_q <= 1'b0;
      end else if (mem_busy && wd_expired && !MemAck) begin
         err_q <= 1'b1;
      end
   end

   assign ErrTimeout = err_q;
`else
   assign wd_expired = 1'b0;
   assign ErrTimeout = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      unique case (state)
         IDLE: begin
            // Data has priority unless the waiting fetch has been starved.
            if (DReqM && !(IReqF && (starve == STARVE_LIM))) begin
               grant_data = 1'b1;
               state_nxt  = DATA;
            end else if (IReqF) begin
               grant_fetch = 1'b1;
               state_nxt   = FETCH;
            end
         end
         FETCH, DATA: begin
            if (txn_done) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         starve     <= '0;
         resp_fetch <= 1'b0;
         MemWe      <= 1'b0;
         MemAddr    <= '0;
         MemWdata   <= '0;
         IRdataF    <= '0;
         DRdataM    <= '0;
      end else begin
         state <= state_nxt;

         if (grant_data) begin
            MemAddr  <= DAddrM;
            MemWe    <= DWeM;
            MemWdata <= DWdataM;
            if (IReqF && (starve != STARVE_LIM)) begin
               starve <= starve + 1'b1;
            end
         end

         if (grant_fetch) begin
            MemAddr  <= IAddrF;
            MemWe    <= 1'b0;
            MemWdata <= '0;
            starve   <= '0;
         end

         if (txn_done) begin
            resp_fetch <= (state == FETCH);
            if (state == FETCH) begin
               IRdataF <= resp_data;
            end else if (!MemWe) begin
               DRdataM <= resp_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
module tb_pipeline_mem_arbiter;
   import arm_pkg::*;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 8;
`else
   localparam int unsigned TB_TIMEOUT = 255;
`endif
   localparam int unsigned TB_STARVE = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IReqF;
   logic [31:0] IAddrF;
   logic [31:0] IRdataF;
   logic        IReadyF;
   logic        DReqM;
   logic        DWeM;
   logic [31:0] DAddrM;
   logic [31:0] DWdataM;
   logic [31:0] DRdataM;
   logic        DReadyM;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWdata;
   logic [31:0] MemRdata;
   logic        MemAck;
   logic        ErrTimeout;

   pipeline_mem_arbiter #(
      .FETCH_STARVE_MAX(TB_STARVE),
      .TIMEOUT_CYCLES  (TB_TIMEOUT)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IReqF     (IReqF),
      .IAddrF    (IAddrF),
      .IRdataF   (IRdataF),
      .IReadyF   (IReadyF),
      .DReqM     (DReqM),
      .DWeM      (DWeM),
      .DAddrM    (DAddrM),
      .DWdataM   (DWdataM),
      .DRdataM   (DRdataM),
      .DReadyM   (DReadyM),
      .MemReq    (MemReq),
      .MemWe     (MemWe),
      .MemAddr   (MemAddr),
      .MemWdata  (MemWdata),
      .MemRdata  (MemRdata),
      .MemAck    (MemAck),
      .ErrTimeout(ErrTimeout)
   );

   always #5 CLK = ~CLK;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] last_dr;

   typedef struct {
      bit          ireq;
      bit          dreq;
      bit          dwe;
      logic [31:0] iaddr;
      logic [31:0] daddr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      bit          exp_fetch_first;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset;
      RST      = 1'b0;
      IReqF    = 1'b0;
      IAddrF   = '0;
      DReqM    = 1'b0;
      DWeM     = 1'b0;
      DAddrM   = '0;
      DWdataM  = '0;
      MemRdata = '0;
      MemAck   = 1'b0;
      last_dr  = '0;
      tick;
      tick;
      RST = 1'b1;
      tick;
   endtask

   // Requests must already be driven with the DUT idle at this negedge.
   task automatic serve_one(input bit is_fetch, input logic [31:0] addr, input bit we,
                            input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
      tick;
      chk("grant_memreq", MemReq, 1);
      chk("grant_addr", MemAddr, addr);
      chk("grant_we", MemWe, we);
      if (we) chk("grant_wdata", MemWdata, wdata);
      for (int k = 0; k < delay; k++) begin
         tick;
         chk("wait_memreq", MemReq, 1);
         chk("wait_noready", {IReadyF, DReadyM}, 0);
      end
      MemAck   = 1'b1;
      MemRdata = rdata;
      tick;
      MemAck   = 1'b0;
      MemRdata = $urandom;
      chk("resp_memreq", MemReq, 0);
      chk("resp_iready", IReadyF, is_fetch);
      chk("resp_dready", DReadyM, !is_fetch);
      if (is_fetch) begin
         chk("resp_irdata", IRdataF, rdata);
         IReqF = 1'b0;
      end else begin
         if (!we) last_dr = rdata;
         chk("resp_drdata", DRdataM, last_dr);
         DReqM = 1'b0;
      end
      tick;
      chk("after_noready", {IReadyF, DReadyM}, 0);
      chk("after_memreq", MemReq, 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int          n;
      int          phase;      // 0 idle, 1 memory busy, 2 response cycle
      int          starve_m;
      int          wait_cnt;
      bit          i_pend, d_pend, ack_now, new_grant, served_fetch, just_dropped;
      bit          g_fetch;
      logic [31:0] exp_addr, exp_wdata, exp_rd;
      bit          exp_we;

      vecs[0] = '{1, 0, 0, 32'h100, 32'h0,   32'h0,  32'hE3A00001, 2, 1};
      vecs[1] = '{0, 1, 0, 32'h0,   32'h300, 32'h0,  32'h12345678, 0, 0};
      vecs[2] = '{0, 1, 1, 32'h0,   32'h200, 32'h55, 32'hAAAA5555, 1, 0};
      vecs[3] = '{1, 1, 0, 32'h500, 32'h400, 32'h0,  32'hCAFEF00D, 0, 0};
      vecs[4] = '{1, 1, 1, 32'h700, 32'h600, 32'h77, 32'h0BADF00D, 3, 0};

      // Reset state
      RST = 1'b0; IReqF = 0; DReqM = 0; DWeM = 0; MemAck = 0;
      IAddrF = '0; DAddrM = '0; DWdataM = '0; MemRdata = '0;
      #1;
      chk("rst_memreq", MemReq, 0);
      chk("rst_ready", {IReadyF, DReadyM}, 0);
      chk("rst_memwe", MemWe, 0);
      chk("rst_memaddr", MemAddr, 0);
      chk("rst_memwdata", MemWdata, 0);
      chk("rst_irdata", IRdataF, 0);
      chk("rst_drdata", DRdataM, 0);
      chk("rst_err", ErrTimeout, 0);
      do_reset;

      // Table-driven single transactions (both-request rows serve the fetch second)
      for (int v = 0; v < 5; v++) begin
         IReqF = vecs[v].ireq; IAddrF = vecs[v].iaddr;
         DReqM = vecs[v].dreq; DWeM = vecs[v].dwe;
         DAddrM = vecs[v].daddr; DWdataM = vecs[v].wdata;
         if (vecs[v].exp_fetch_first)
            serve_one(1, vecs[v].iaddr, 0, 0, vecs[v].delay, vecs[v].rdata);
         else
            serve_one(0, vecs[v].daddr, vecs[v].dwe, vecs[v].wdata, vecs[v].delay, vecs[v].rdata);
         if (vecs[v].ireq && vecs[v].dreq)
            serve_one(1, vecs[v].iaddr, 0, 0, 0, vecs[v].rdata ^ 32'hFFFF_FFFF);
      end

      // Fetch starvation: four data grants, then the fetch, then data again
      do_reset;
      IReqF = 1'b1; IAddrF = 32'h800;
      for (int g = 0; g < 7; g++) begin
         DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h900 + 32'(g * 4);
         if (g == 4) serve_one(1, 32'h800, 0, 0, 0, 32'h11110000 + 32'(g));
         else        serve_one(0, DAddrM, 0, 0, g % 2, 32'h22220000 + 32'(g));
         DReqM = 1'b1;
      end
      DReqM = 1'b0;

      // Reset in the middle of DATA
      do_reset;
      DReqM = 1'b1; DAddrM = 32'hA00;
      tick;
      chk("mid_memreq_before", MemReq, 1);
      RST = 1'b0;
      #1;
      chk("mid_memreq", MemReq, 0);
      chk("mid_ready", {IReadyF, DReadyM}, 0);
      chk("mid_memaddr", MemAddr, 0);
      DReqM = 1'b0; MemAck = 1'b1;
      tick;
      RST = 1'b1; MemAck = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk("post_rst_memreq", MemReq, 0);
         chk("post_rst_ready", {IReadyF, DReadyM}, 0);
      end
      IReqF = 1'b1; IAddrF = 32'hB00;
      serve_one(1, 32'hB00, 0, 0, 0, 32'h0000B00B);

`ifdef MEM_ARB_TIMEOUT_EN
      // MemAck in the expiry cycle wins over the watchdog
      do_reset;
      DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'hC00;
      serve_one(0, 32'hC00, 0, 0, TB_TIMEOUT - 1, 32'h1234ABCD);
      chk("ack_prio_err", ErrTimeout, 0);

      // Watchdog expiry
      DReqM = 1'b1; DAddrM = 32'hD00;
      tick;
      n = 0;
      while (!DReadyM && n < 20) begin
         tick;
         n++;
      end
      chk("timeout_latency", n, TB_TIMEOUT);
      chk("timeout_dready", DReadyM, 1);
      chk("timeout_iready", IReadyF, 0);
      chk("timeout_data", DRdataM, 32'hDEADBEEF);
      chk("timeout_err", ErrTimeout, 1);
      last_dr = 32'hDEADBEEF;
      DReqM = 1'b0;
      tick;
      chk("timeout_err_sticky", ErrTimeout, 1);
      IReqF = 1'b1; IAddrF = 32'hD40;
      serve_one(1, 32'hD40, 0, 0, 0, 32'h00D4000D);
      chk("timeout_err_sticky2", ErrTimeout, 1);
      do_reset;
      chk("timeout_err_cleared", ErrTimeout, 0);
`else
      // No watchdog: a long wait still completes normally
      do_reset;
      DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'hE00;
      serve_one(0, 32'hE00, 0, 0, 20, 32'h0E0E0E0E);
      chk("no_wd_err", ErrTimeout, 0);
`endif

      // Randomized traffic against a transaction-level reference model
      do_reset;
      phase = 0; starve_m = 0; wait_cnt = 0;
      i_pend = 0; d_pend = 0; served_fetch = 0; just_dropped = 0;
      exp_addr = '0; exp_wdata = '0; exp_we = 0; exp_rd = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         ack_now = 0;
         new_grant = 0;
         if (phase == 1) begin
            wait_cnt++;
            if ($urandom_range(0, 2) == 0 || wait_cnt >= 4) begin
               MemAck = 1'b1; MemRdata = $urandom; ack_now = 1;
            end else begin
               MemAck = 1'b0;
            end
         end else begin
            // spurious acks outside a transaction must be ignored
            MemAck   = ($urandom_range(0, 3) == 0);
            MemRdata = $urandom;
         end
         if (!just_dropped) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
               i_pend = 1; IReqF = 1'b1; IAddrF = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && $urandom_range(0, 1) == 0) begin
               d_pend = 1; DReqM = 1'b1; DAddrM = $urandom & 32'hFFFF_FFFC;
               DWeM = $urandom_range(0, 1); DWdataM = $urandom;
            end
         end
         just_dropped = 0;

         if (phase == 0) begin
            if (i_pend || d_pend) begin
               g_fetch = !(d_pend && !(i_pend && starve_m == TB_STARVE));
               if (g_fetch) begin
                  starve_m = 0;
                  exp_addr = IAddrF; exp_we = 0; exp_wdata = '0;
               end else begin
                  if (i_pend && starve_m < TB_STARVE) starve_m++;
                  exp_addr = DAddrM; exp_we = DWeM; exp_wdata = DWdataM;
               end
               served_fetch = g_fetch;
               phase = 1; wait_cnt = 0; new_grant = 1;
            end
         end else if (phase == 1) begin
            if (ack_now) begin
               phase = 2; exp_rd = MemRdata;
            end
         end else begin
            phase = 0;
         end

         tick;
         chk("rnd_memreq", MemReq, phase == 1);
         if (new_grant) begin
            chk("rnd_addr", MemAddr, exp_addr);
            chk("rnd_we", MemWe, exp_we);
            if (exp_we) chk("rnd_wdata", MemWdata, exp_wdata);
         end
         if (phase == 2) begin
            chk("rnd_iready", IReadyF, served_fetch);
            chk("rnd_dready", DReadyM, !served_fetch);
            if (served_fetch) begin
               chk("rnd_irdata", IRdataF, exp_rd);
               IReqF = 1'b0; i_pend = 0;
            end else begin
               if (!exp_we) last_dr = exp_rd;
               chk("rnd_drdata", DRdataM, last_dr);
               DReqM = 1'b0; d_pend = 0;
            end
            just_dropped = 1;
         end else begin
            chk("rnd_noready", {IReadyF, DReadyM}, 0);
         end
      end
      chk("rnd_err", ErrTimeout, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pipeline_mem_arbiter.md
PIPELINE_MEM_ARBITER -- requirements
Module: pipeline_mem_arbiter

Interface
REQ-001 SHALL have parameter FETCH_STARVE_MAX, default 4: max consecutive data grants while a fetch waits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit in cycles, range 1..255.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports IReqF input 1 fetch request; IAddrF input 32 fetch address.
REQ-006 SHALL have ports IRdataF output 32 fetched instruction; IReadyF output 1 fetch-done pulse.
REQ-007 SHALL have ports DReqM input 1 data request; DWeM input 1 write enable; DAddrM input 32 address; DWdataM input 32 write data.
REQ-008 SHALL have ports DRdataM output 32 load data; DReadyM output 1 data-done pulse.
REQ-009 SHALL have memory-side outputs MemReq 1, MemWe 1, MemAddr 32, MemWdata 32, and inputs MemRdata 32, MemAck 1.
REQ-010 SHALL have port ErrTimeout  output  1  sticky watchdog error flag.

Function
REQ-011 SHALL share one memory port between fetch and memory-stage data access using states IDLE, FETCH, DATA and RESP.
REQ-012 SHALL move from IDLE to DATA when DReqM=1, unless the starve counter equals FETCH_STARVE_MAX and IReqF=1; then it SHALL go to FETCH.
REQ-013 SHALL move from IDLE to FETCH when IReqF=1 and DReqM=0, and SHALL stay in IDLE when neither request is high.
REQ-014 SHALL latch the address, write enable and write data into MemAddr, MemWe and MemWdata on the grant edge. MemWe SHALL be 0 for a fetch.
REQ-015 SHALL hold MemReq=1 for every cycle in FETCH or DATA and keep it 0 in IDLE and RESP.
REQ-016 SHALL go to RESP on the edge where MemAck=1 is sampled in FETCH or DATA, and SHALL ignore MemAck in IDLE and RESP.
REQ-017 SHALL, on that edge, register MemRdata into IRdataF (fetch) or into DRdataM (data read). DRdataM SHALL keep its value on writes.
REQ-018 SHALL assert exactly one of IReadyF or DReadyM for the single RESP cycle, then return to IDLE.
REQ-019 SHALL ignore requests while in RESP. A requester SHALL drop its request on the edge that samples its ready pulse.
REQ-020 SHALL give a minimum latency from request to ready of 3 cycles: grant edge, ack edge, RESP cycle (with MemAck=1 in the first FETCH/DATA cycle).
REQ-021 SHALL increment the saturating starve counter on each data grant made while IReqF=1, and clear it on each fetch grant.
REQ-022 SHALL give MemAck priority when MemAck=1 and the watchdog expires in the same cycle.

Reset
REQ-023 SHALL, while RST=0, set the state to IDLE and clear the starve and watchdog counters and every output, including ErrTimeout.
REQ-024 SHALL abort any in-flight transaction on reset without issuing a ready pulse.

Configuration
REQ-025 SHALL compile the watchdog when macro MEM_ARB_TIMEOUT_EN is defined.
REQ-026 SHALL, with MEM_ARB_TIMEOUT_EN, count cycles spent in FETCH/DATA.
REQ-027 SHALL, when that count reaches TIMEOUT_CYCLES without MemAck, go to RESP, load 32'hDEADBEEF into the served read-data output and set ErrTimeout=1.
REQ-028 SHALL, without MEM_ARB_TIMEOUT_EN, wait for MemAck indefinitely and tie ErrTimeout to 0; the port list SHALL be identical in both builds.

Structure
REQ-029 SHALL place the state enum, the 32'hDEADBEEF constant and the 32-bit word-width constant in shared package arm_pkg.
REQ-030 SHALL implement the watchdog as sub-module mem_arb_watchdog, with inputs count-enable and clear and output expired, instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-031 SHALL cover: IReqF=1, IAddrF=0x100, MemAck after 2 cycles, MemRdata=0xE3A00001 -> IReadyF pulse, IRdataF=0xE3A00001, MemWe=0.
REQ-032 SHALL cover: IReqF=1 and DReqM=1 raised in the same cycle -> DATA granted first, then FETCH.
REQ-033 SHALL cover: DReqM held high for 6 transactions with IReqF=1 -> FETCH granted after the 4th data grant.
REQ-034 SHALL cover: DReqM=1, DWeM=1, DAddrM=0x200, DWdataM=0x55 -> MemWe=1, MemWdata=0x55, DReadyM pulse, DRdataM unchanged.
REQ-035 SHALL cover: RST driven low in the middle of DATA -> MemReq=0, no ready pulse, state IDLE.
REQ-036 SHALL cover: with MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, MemAck never asserted -> DReadyM pulse after 8 cycles, DRdataM=0xDEADBEEF, ErrTimeout=1 until reset.
